sd_sector_bist: RTL
===================

SD_SECTOR_BIST -- requirements
Module: sd_sector_bist

Interface
REQ-001 Parameter TEST_SECTOR, default 32'd8192: sector address written, then read back.
REQ-002 Parameter SEED, default 8'hA5: pattern seed.
REQ-003 Parameter TIMEOUT_CYC, default 32'd50_000_000: per-phase cycle limit.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle run request.
REQ-007 sd_init_done  input  1  card ready, from sd_card_top.
REQ-008 sd_sec_write / sd_sec_write_addr  output  1 / 32  write request / sector address.
REQ-009 sd_sec_write_data  output  8  write byte.
REQ-010 sd_sec_write_data_req / sd_sec_write_end  input  1 / 1  byte request / write complete.
REQ-011 sd_sec_read / sd_sec_read_addr  output  1 / 32  read request / sector address.
REQ-012 sd_sec_read_data / sd_sec_read_data_valid / sd_sec_read_end  input  8 / 1 / 1  read byte / byte strobe / read complete.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  one-cycle pulse at end of run.
REQ-015 pass  output  1  last run passed; held until next start.
REQ-016 err_code  output  3  0 none, 1 timeout, 2 write length, 3 read length, 4 mismatch, 5 init lost.
REQ-017 err_cnt  output  10  mismatching bytes in last run (0..512).

Function
REQ-018 States: IDLE, WAIT_INIT, WRITE, READ, FINISH.
REQ-019 IDLE: start -> WAIT_INIT; clears pass, err_code, err_cnt, byte index, timeout counter; busy=1 from the next cycle.
REQ-020 start while busy is ignored.
REQ-021 WAIT_INIT: sd_init_done=1 -> WRITE; timeout -> FINISH, code 1.
REQ-022 pattern(k) = k[7:0] XOR {7'b0,k[8]} XOR SEED, for k = 0..511.
REQ-023 WRITE: sd_sec_write=1 and sd_sec_write_addr=TEST_SECTOR, held until sd_sec_write_end.
REQ-024 sd_sec_write_data is registered, equals pattern(wr_idx); wr_idx increments on each sd_sec_write_data_req, so byte 0 is valid before the first req.
REQ-025 sd_sec_write_end with wr_idx==512 -> READ; any other count -> FINISH, code 2.
REQ-026 READ: sd_sec_read=1 and sd_sec_read_addr=TEST_SECTOR, held until sd_sec_read_end.
REQ-027 Each sd_sec_read_data_valid with rd_idx<512: compare against pattern(rd_idx), increment err_cnt on mismatch, increment rd_idx.
REQ-028 Strobes with rd_idx>=512 are not compared and set a length-error flag.
REQ-029 sd_sec_read_end: rd_idx!=512 or flag set -> code 3; else err_cnt!=0 -> code 4; else pass=1; then FINISH.
REQ-030 Simultaneous valid and read_end: the byte is compared before the end is evaluated.
REQ-031 Timeout counter resets on each phase entry; reaching TIMEOUT_CYC in WRITE or READ -> FINISH, code 1, request dropped.
REQ-032 sd_init_done falling in WRITE or READ -> FINISH, code 5, request dropped the next cycle.
REQ-033 FINISH: done=1 for one cycle, busy=0, -> IDLE.
REQ-034 At most one of sd_sec_write and sd_sec_read is high in any cycle.

Reset
REQ-035 All outputs 0 on reset except the address outputs, which are TEST_SECTOR; state=IDLE.
REQ-036 Reset mid-run drops both requests on the first clock edge with rst high; no done pulse is produced.

Structure
REQ-037 Package sd_bist_pkg holds the state enum, err_code constants and SECTOR_BYTES=512.
REQ-038 One sub-module, sd_bist_pattern: combinational pattern(k) generator, instantiated once for write and once for compare.

Verification
REQ-039 Card model with init at cycle 100, correct echo -> done pulse, pass=1, err_code=0, err_cnt=0, write bytes 0..2 = A5,A4,A7.
REQ-040 Model corrupts read bytes 10 and 300 -> pass=0, err_code=4, err_cnt=2.
REQ-041 Model ends write after 511 reqs -> err_code=2, sd_sec_read never asserted.
REQ-042 sd_init_done held low with TIMEOUT_CYC=1000 -> done at ~1001 cycles after start, err_code=1.
REQ-043 sd_init_done dropped during READ -> sd_sec_read low the next cycle, err_code=5; a second start mid-run is ignored.
REQ-044 rst asserted mid-WRITE -> all outputs at reset values after one edge; a fresh start passes.

Source files
------------

// File: rtl/sd_bist_pkg.sv
// rtl/sd_bist_pkg.sv - shared types and constants for the SD sector self test
//   state_t        : controller states
//   ERR_*          : err_code values reported at the end of a run
//   SECTOR_BYTES   : bytes per SD sector
//   SECTOR_IDX_END : SECTOR_BYTES as a 10-bit byte-index value
package sd_bist_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam logic [9:0] SECTOR_IDX_END = 10'(SECTOR_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ      = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd1;
    localparam logic [2:0] ERR_WR_LEN    = 3'd2;
    localparam logic [2:0] ERR_RD_LEN    = 3'd3;
    localparam logic [2:0] ERR_MISMATCH  = 3'd4;
    localparam logic [2:0] ERR_INIT_LOST = 3'd5;

endpackage

// File: rtl/sd_bist_pattern.sv
// rtl/sd_bist_pattern.sv - combinational test byte generator
//   idx  : byte index within the sector (0..511)
//   data : idx[7:0] ^ idx[8] ^ SEED
module sd_bist_pattern #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic [8:0] idx,
    output logic [7:0] data
);

    // Folding bit 8 into bit 0 makes the second half of the sector differ
    // from the first half, so an address-bit-8 fault shows up as mismatches.
    assign data = idx[7:0] ^ {7'b0, idx[8]} ^ SEED;

endmodule

// File: rtl/sd_sector_bist.sv
// rtl/sd_sector_bist.sv - writes one sector with a known pattern, reads it back and checks it
//   clk, rst                       : clock, synchronous active-high reset
//   start                          : single-cycle run request (ignored while busy)
//   sd_init_done                   : card ready
//   sd_sec_write / _addr / _data   : sector write request, address, registered write byte
//   sd_sec_write_data_req / _end   : byte request / write complete from the card controller
//   sd_sec_read / _addr            : sector read request, address
//   sd_sec_read_data / _valid/_end : read byte, byte strobe, read complete
//   busy, done, pass               : run in progress, end-of-run pulse, last run passed
//   err_code, err_cnt              : failure reason, mismatching byte count of last run
module sd_sector_bist
    import sd_bist_pkg::*;
#(
    parameter logic [31:0] TEST_SECTOR = 32'd8192,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sd_init_done,
    output logic        sd_sec_write,
    output logic [31:0] sd_sec_write_addr,
    output logic [7:0]  sd_sec_write_data,
    input  logic        sd_sec_write_data_req,
    input  logic        sd_sec_write_end,
    output logic        sd_sec_read,
    output logic [31:0] sd_sec_read_addr,
    input  logic [7:0]  sd_sec_read_data,
    input  logic        sd_sec_read_data_valid,
    input  logic        sd_sec_read_end,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [9:0]  err_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  fin_code;

    logic [31:0] tmo_cnt;
    logic        tmo_hit;

    logic [9:0]  wr_idx;
    logic [9:0]  wr_idx_nxt;
    logic [7:0]  wr_pat;
    logic [7:0]  wr_data_q;

    logic [9:0]  rd_idx;
    logic [9:0]  rd_idx_nxt;
    logic [7:0]  rd_pat;
    logic        rd_hit;
    logic        rd_in_range;
    logic        rd_mismatch;
    logic [9:0]  err_cnt_q;
    logic [9:0]  err_cnt_nxt;
    logic        len_err;
    logic        len_err_nxt;

    logic        pass_q;
    logic [2:0]  err_code_q;
    logic        start_run;

    assign start_run = (state == ST_IDLE) && start;
    assign tmo_hit   = (tmo_cnt >= (TIMEOUT_CYC - 32'd1));

    sd_bist_pattern #(.SEED(SEED)) u_wr_pat (
        .idx  (wr_idx_nxt[8:0]),
        .data (wr_pat)
    );

    sd_bist_pattern #(.SEED(SEED)) u_rd_pat (
        .idx  (rd_idx[8:0]),
        .data (rd_pat)
    );

    // The write byte register is loaded from the index the next cycle will
    // hold, so byte k is on sd_sec_write_data while the k-th request is high.
    // The index stops at 513: any count past 512 is already a length error.
    always_comb begin
        wr_idx_nxt = wr_idx;
        if (start_run) begin
            wr_idx_nxt = '0;
        end else if ((state == ST_WRITE) && sd_sec_write_data_req
                     && (wr_idx <= SECTOR_IDX_END)) begin
            wr_idx_nxt = wr_idx + 10'd1;
        end
    end

    // Read-side next values include the byte strobed this cycle, so a strobe
    // coinciding with sd_sec_read_end is counted before the end is judged.
    assign rd_hit      = (state == ST_READ) && sd_sec_read_data_valid;
    assign rd_in_range = (rd_idx < SECTOR_IDX_END);
    assign rd_mismatch = rd_hit && rd_in_range && (sd_sec_read_data != rd_pat);
    assign rd_idx_nxt  = rd_idx + {9'd0, rd_hit && rd_in_range};
    assign err_cnt_nxt = err_cnt_q + {9'd0, rd_mismatch};
    assign len_err_nxt = len_err | (rd_hit && !rd_in_range);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; fin_code is the result latched when entering FINISH.
    // Losing the card takes priority over a same-cycle end or timeout.
    always_comb begin
        state_nxt = state;
        fin_code  = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT_INIT;
                end
            end
            ST_WAIT_INIT: begin
                if (sd_init_done) begin
                    state_nxt = ST_WRITE;
                end else if (tmo_hit) begin
                    state_nxt = ST_FINISH;
                    fin_code  = ERR_TIMEOUT;
                end
            end
            ST_WRITE: begin
                if (!sd_init_done) begin
                    state_nxt = ST_FINISH;
                    fin_code  = ERR_INIT_LOST;
                end else if (sd_sec_write_end) begin
                    if (wr_idx == SECTOR_IDX_END) begin
                        state_nxt = ST_READ;
                    end else begin
                        state_nxt = ST_FINISH;
                        fin_code  = ERR_WR_LEN;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_FINISH;
                    fin_code  = ERR_TIMEOUT;
                end
            end
            ST_READ: begin
                if (!sd_init_done) begin
                    state_nxt = ST_FINISH;
                    fin_code  = ERR_INIT_LOST;
                end else if (sd_sec_read_end) begin
                    state_nxt = ST_FINISH;
                    if ((rd_idx_nxt != SECTOR_IDX_END) || len_err_nxt) begin
                        fin_code = ERR_RD_LEN;
                    end else if (err_cnt_nxt != 10'd0) begin
                        fin_code = ERR_MISMATCH;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_FINISH;
                    fin_code  = ERR_TIMEOUT;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode; requests follow the state so they drop in the cycle
    // after the state leaves WRITE/READ (including on reset).
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        sd_sec_write = 1'b0;
        sd_sec_read  = 1'b0;
        case (state)
            ST_WAIT_INIT: busy = 1'b1;
            ST_WRITE: begin
                busy         = 1'b1;
                sd_sec_write = 1'b1;
            end
            ST_READ: begin
                busy        = 1'b1;
                sd_sec_read = 1'b1;
            end
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            wr_idx     <= '0;
            wr_data_q  <= '0;
            rd_idx     <= '0;
            err_cnt_q  <= '0;
            len_err    <= 1'b0;
            pass_q     <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            // Phase timer restarts whenever the state changes.
            if ((state == ST_IDLE) || (state_nxt != state)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            wr_idx <= wr_idx_nxt;
            if (start_run || (state == ST_WRITE)) begin
                wr_data_q <= wr_pat;
            end

            if (start_run) begin
                rd_idx     <= '0;
                err_cnt_q  <= '0;
                len_err    <= 1'b0;
                pass_q     <= 1'b0;
                err_code_q <= ERR_NONE;
            end else begin
                if (state == ST_READ) begin
                    rd_idx    <= rd_idx_nxt;
                    err_cnt_q <= err_cnt_nxt;
                    len_err   <= len_err_nxt;
                end
                if (state_nxt == ST_FINISH) begin
                    err_code_q <= fin_code;
                    pass_q     <= (state == ST_READ) && (fin_code == ERR_NONE);
                end
            end
        end
    end

    assign sd_sec_write_addr = TEST_SECTOR;
    assign sd_sec_read_addr  = TEST_SECTOR;
    assign sd_sec_write_data = wr_data_q;
    assign pass              = pass_q;
    assign err_code          = err_code_q;
    assign err_cnt           = err_cnt_q;

endmodule
